grf_mp: RTL and testbench

//  Parametrised general register file: 2 write ports, NREAD read ports, same-cycle write-to-read bypass.
//  Per-register busy scoreboard for the pipeline hazard unit, plus an outstanding-write counter.

---
 rtl/grf_mp.sv | 135 +++++++++++++
 tb/tb_grf_mp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_mp.sv
// -----------------------------------------------------------------------------
// grf_mp : general register file, 2 write ports, NREAD read ports.
//
// Register 0 always reads as zero. Each read port sees a same-cycle write
// through a bypass: port 1 data first, then port 0 data, then the array.
// A per-register busy scoreboard is kept for the hazard unit, together with a
// registered count of the busy registers.
//
// Parameters
//   DATA_W  register width
//   ADDR_W  address width, DEPTH = 2**ADDR_W
//   NREAD   number of read ports (>= 1)
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   we0/wa0/wd0/pc0         write port 0 (writeback stage) with trace PC
//   we1/wa1/wd1/pc1         write port 1 (long-latency unit) with trace PC
//   ra   [NREAD*ADDR_W]     read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd   [NREAD*DATA_W]     read data,      port i = rd[i*DATA_W +: DATA_W]
//   rbusy[NREAD]            source register busy and not bypassed this cycle
//   iss_en/iss_addr         issue: mark iss_addr busy
//   busy_cnt[ADDR_W+1]      number of busy registers
//
// Configuration macro
//   GRF_TRACE_EN  when defined, every effective register write is printed
//                 (port 0 first, then port 1). When undefined pc0/pc1 are
//                 unused.
// -----------------------------------------------------------------------------
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic [31:0]             pc0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic [31:0]             pc1,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [ADDR_W:0]         busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              we0_eff;
  logic              we1_eff;

  // Port 1 wins an address collision, so port 0 is suppressed in that case.
  assign we1_eff = we1 && (wa1 != '0);
  assign we0_eff = we0 && (wa0 != '0) && !(we1_eff && (wa1 == wa0));

  // NOTE: the file is built from flops, so clearing every entry on reset is
  // legal here; a RAM-macro implementation could not be reset this way.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (we0_eff) regs[wa0] <= wd0;
      if (we1_eff) regs[wa1] <= wd1;
    end
  end

  // Scoreboard next state. An issue to r beats a writeback to r because the
  // new producer is the one the pipeline must wait for.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int r = 1; r < DEPTH; r++) begin
      if (iss_en && (iss_addr == ADDR_W'(r)))
        busy_nxt[r] = 1'b1;
      else if ((we0 && (wa0 == ADDR_W'(r))) || (we1 && (wa1 == ADDR_W'(r))))
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
    // Counting the next-state bits yields exactly the net +/- change of the
    // set/clear events that actually flip a bit.
    for (int r = 1; r < DEPTH; r++) cnt_nxt = cnt_nxt + (ADDR_W + 1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports with same-cycle bypass; outputs are held at zero during reset.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit1;
    logic              hit0;

    assign a    = ra[i*ADDR_W +: ADDR_W];
    assign hit1 = we1 && (wa1 == a);
    assign hit0 = we0 && (wa0 == a);

    assign rd[i*DATA_W +: DATA_W] = (reset || (a == '0)) ? '0   :
                                    hit1                 ? wd1  :
                                    hit0                 ? wd0  :
                                                           regs[a];
    assign rbusy[i] = !reset && (a != '0) && busy[a] && !(hit1 || hit0);
  end

`ifdef GRF_TRACE_EN
  // Trace of effective writes; a port 0 write lost to port 1 is not printed.
  always_ff @(posedge clk) begin
    if (!reset && we0_eff) $display("%d@%h: $%d <= %h", $time, pc0, wa0, wd0);
    if (!reset && we1_eff) $display("%d@%h: $%d <= %h", $time, pc1, wa1, wd1);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{pc0, pc1};
`endif

endmodule

// File: tb/tb_grf_mp.sv
// -----------------------------------------------------------------------------
// tb_grf_mp : scoreboard bench for grf_mp.
// The driver computes the expected outputs from a reference model (array of
// registers plus a set of busy register numbers) and queues them; a monitor
// process pops and compares them against the DUT in the same cycle.
// -----------------------------------------------------------------------------
module tb_grf_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    we0, we1, iss_en;
  logic [ADDR_W-1:0]       wa0, wa1, iss_addr;
  logic [DATA_W-1:0]       wd0, wd1;
  logic [31:0]             pc0, pc1;
  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*DATA_W-1:0] rd;
  logic [NREAD-1:0]        rbusy;
  logic [ADDR_W:0]         busy_cnt;

  grf_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
    .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREAD*DATA_W-1:0] rd;
    logic [NREAD-1:0]        rbusy;
    logic [ADDR_W:0]         cnt;
    int                      tag;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [int];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                tag_cur = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected combinational outputs for the current inputs and model state.
  function automatic exp_t model_out();
    exp_t e;
    e.rd    = '0;
    e.rbusy = '0;
    e.cnt   = (ADDR_W + 1)'(m_busy.num());
    e.tag   = tag_cur;
    for (int i = 0; i < NREAD; i++) begin
      int                a;
      logic [DATA_W-1:0] v;
      bit                fwd;
      a   = int'(ra[i*ADDR_W +: ADDR_W]);
      fwd = 1'b1;
      if (a == 0)                         v = '0;
      else if (we1 && int'(wa1) == a)     v = wd1;
      else if (we0 && int'(wa0) == a)     v = wd0;
      else begin                          v = m_regs[a]; fwd = 1'b0; end
      if (reset) v = '0;
      e.rd[i*DATA_W +: DATA_W] = v;
      e.rbusy[i] = !reset && (a != 0) && !fwd && m_busy.exists(a);
    end
    return e;
  endfunction

  // Model state update at a clock edge.
  task automatic model_edge();
    if (reset) begin
      foreach (m_regs[r]) m_regs[r] = '0;
      m_busy.delete();
    end else begin
      if (we0 && wa0 != 0) m_regs[int'(wa0)] = wd0;
      if (we1 && wa1 != 0) m_regs[int'(wa1)] = wd1;  // applied last: port 1 wins
      if (we0) m_busy.delete(int'(wa0));
      if (we1) m_busy.delete(int'(wa1));
      if (iss_en && iss_addr != 0) m_busy[int'(iss_addr)] = 1'b1;  // issue wins
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
    sb.push_back(model_out());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic cycle(input bit chk);
    if (chk) sample();
    else     @(negedge clk);
    tick();
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0; pc0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0; pc1 = '0;
    iss_en = 0; iss_addr = '0;
  endtask

  task automatic set_ra(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    ra = {a1, a0};
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom);
  endfunction

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("t%0d_rd", e.tag),       rd,       e.rd);
        check($sformatf("t%0d_rbusy", e.tag),    rbusy,    e.rbusy);
        check($sformatf("t%0d_busy_cnt", e.tag), busy_cnt, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    ra    = '0;
    reset = 1'b1;

    // 1: reset, then sweep all addresses on both ports
    tag_cur = 1;
    cycle(0);
    cycle(1);
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      set_ra(ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
      cycle(1);
    end

    // 2: same-cycle bypass, then stored value
    tag_cur = 2;
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; pc0 = 32'h100;
    set_ra(5, 0);
    sample();
    check("t2_bypass", rd[31:0], 32'hDEADBEEF);
    tick();
    we0 = 0;
    sample();
    check("t2_stored", rd[31:0], 32'hDEADBEEF);
    tick();

    // 3: both ports to one address, port 1 wins
    tag_cur = 3;
    we0 = 1; wa0 = 7; wd0 = 1;
    we1 = 1; wa1 = 7; wd1 = 2;
    set_ra(7, 7);
    sample();
    check("t3_bypass", rd[31:0], 32'd2);
    tick();
    idle();
    sample();
    check("t3_stored", rd[63:32], 32'd2);
    tick();

    // 4: writes and issues to register 0 have no effect
    tag_cur = 4;
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 0;
    set_ra(0, 0);
    sample();
    check("t4_rd_zero", rd, 64'd0);
    tick();
    idle();
    cycle(1);

    // 5: scoreboard set/clear and issue-beats-writeback
    tag_cur = 5;
    iss_en = 1; iss_addr = 3; cycle(1);
    iss_addr = 4; cycle(1);
    idle();
    set_ra(3, 0);
    sample();
    check("t5_cnt2",   busy_cnt, 6'd2);
    check("t5_rbusy3", rbusy[0], 1'b1);
    tick();
    we0 = 1; wa0 = 3; wd0 = 33;
    sample();
    check("t5_bypass_unbusy", rbusy[0], 1'b0);
    tick();
    idle();
    sample();
    check("t5_cnt1", busy_cnt, 6'd1);
    tick();
    iss_en = 1; iss_addr = 4;
    we1 = 1; wa1 = 4; wd1 = 44;
    cycle(1);
    idle();
    set_ra(0, 4);
    sample();
    check("t5_issue_wins_cnt", busy_cnt, 6'd1);
    check("t5_issue_wins_busy", rbusy[1], 1'b1);
    tick();

    // 6: reset mid-operation
    tag_cur = 6;
    iss_en = 1; iss_addr = 9; cycle(1);
    idle();
    set_ra(9, 9);
    cycle(1);
    reset = 1'b1;
    sample();
    check("t6_rd_in_reset",    rd,    64'd0);
    check("t6_rbusy_in_reset", rbusy, 2'b00);
    tick();
    reset = 1'b0;
    set_ra(5, 9);
    sample();
    check("t6_cnt_cleared",  busy_cnt, 6'd0);
    check("t6_regs_cleared", rd,       64'd0);
    check("t6_rbusy",        rbusy,    2'b00);
    tick();

    // 7: randomized traffic
    tag_cur = 7;
    for (int n = 0; n < 500; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      we0      = $urandom_range(0, 1) == 1;
      wa0      = rnd_addr();
      wd0      = $urandom;
      pc0      = $urandom;
      we1      = $urandom_range(0, 2) == 0;
      wa1      = rnd_addr();
      wd1      = $urandom;
      pc1      = $urandom;
      iss_en   = $urandom_range(0, 1) == 1;
      iss_addr = rnd_addr();
      set_ra(rnd_addr(), rnd_addr());
      cycle(1);
    end
    reset = 1'b0;
    idle();

    @(negedge clk);
    @(negedge clk);
    #3;
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
